// File: rtl/vga_pkg.sv
// Shared VGA timing constants and the fetch FSM state type.
// Used by pixel_fetch now; the vga block will move onto it too.
package vga_pkg;

  localparam int H_VISIBLE      = 640;
  localparam int H_TOTAL        = 800;
  localparam int V_VISIBLE      = 480;
  localparam int V_TOTAL        = 525;
  localparam int WORDS_PER_LINE = H_VISIBLE / 8;
  localparam int PREFETCH_H     = 760;
  localparam int ADDR_W         = 16;
  localparam int HC_W           = 11;
  localparam int VC_W           = 10;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    FULL
  } fetch_state_e;

endpackage

// File: rtl/fetch_sched.sv
// Decodes hcounter/vcounter into fetch triggers and pixel load events.
// Purely combinational; all state lives in pixel_fetch.
module fetch_sched
  import vga_pkg::*;
(
  input  logic [HC_W-1:0] hcounter_i,
  input  logic [VC_W-1:0] vcounter_i,
  output logic            trig_o,
  output logic            first_o,
  output logic            load_o,
  output logic            blank_o
);

  localparam logic [HC_W-1:0] GRP_LIM = HC_W'(H_VISIBLE - 8);
  localparam logic [HC_W-1:0] H_LAST  = HC_W'(H_TOTAL - 1);
  localparam logic [HC_W-1:0] H_VLAST = HC_W'(H_VISIBLE - 1);
  localparam logic [HC_W-1:0] H_PRE   = HC_W'(PREFETCH_H);
  localparam logic [VC_W-1:0] V_LAST  = VC_W'(V_TOTAL - 1);
  localparam logic [VC_W-1:0] V_VIS   = VC_W'(V_VISIBLE);

  logic [VC_W-1:0] vnext;
  logic            vis;
  logic            nvis;
  logic            in_grp;
  logic            pre;
  logic            last;

  // Group 79 has no successor on the line, so group edges stop at 631.
  always_comb begin
    vnext   = (vcounter_i == V_LAST) ? '0 : vcounter_i + VC_W'(1);
    vis     = vcounter_i < V_VIS;
    nvis    = vnext < V_VIS;
    in_grp  = hcounter_i < GRP_LIM;
    pre     = hcounter_i == H_PRE;
    last    = hcounter_i == H_LAST;
    trig_o  = (vis && in_grp && hcounter_i[2:0] == 3'd0)
           || (pre && nvis);
    first_o = pre && vnext == '0;
    load_o  = (vis && in_grp && hcounter_i[2:0] == 3'd7)
           || (last && nvis);
    blank_o = (hcounter_i == H_VLAST) || (last && !nvis);
  end

endmodule

// File: rtl/pixel_fetch.sv
// Fetches 1bpp framebuffer bytes one group ahead of the vga scan.
// Late responses blank the group and raise a sticky underrun flag.
module pixel_fetch
  import vga_pkg::*;
(
  input  logic              clk,
  input  logic              reset,
  input  logic [HC_W-1:0]   hcounter,
  input  logic [VC_W-1:0]   vcounter,
  output logic              rd_req,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_ack,
  input  logic [7:0]        rd_data,
  output logic [7:0]        pixels,
  output logic              underrun,
  input  logic              underrun_clr
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [ADDR_W-1:0] base;
  logic [7:0]        buf_q, buf_d;
  logic [7:0]        pix_q, pix_d;
  logic              und_q, und_d;
  logic              und_set;
  logic              ack_ok;
  logic              trig, first, load, blank;

  fetch_sched u_sched (
    .hcounter_i (hcounter),
    .vcounter_i (vcounter),
    .trig_o     (trig),
    .first_o    (first),
    .load_o     (load),
    .blank_o    (blank)
  );

  assign ack_ok   = (state_q == REQ) && rd_ack;
  assign rd_req   = (state_q == REQ);
  assign rd_addr  = rd_addr_q;
  assign pixels   = pix_q;
  assign underrun = und_q;

  // Next-state decode; a load with a same-cycle ack bypasses FULL.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (trig) state_d = REQ;
      REQ: begin
        if (ack_ok && load) state_d = IDLE;
        else if (ack_ok)    state_d = FULL;
      end
      FULL: begin
        if (load)      state_d = IDLE;
        else if (trig) state_d = REQ;
      end
      default: state_d = IDLE;
    endcase
  end

  // Address counter, buffer, pixel byte and underrun updates.
  always_comb begin
    addr_d    = addr_q;
    rd_addr_d = rd_addr_q;
    buf_d     = buf_q;
    pix_d     = pix_q;
    und_set   = 1'b0;
    base      = first ? '0 : addr_q;
    if (trig) begin
      addr_d = base + ADDR_W'(1);
      if (state_q == REQ) und_set = 1'b1;
      else                rd_addr_d = base;
    end
    if (ack_ok) buf_d = rd_data;
    if (load) begin
      if (state_q == FULL) begin
        pix_d = buf_q;
      end else if (ack_ok) begin
        pix_d = rd_data;
      end else begin
        pix_d   = 8'h00;
        und_set = 1'b1;
      end
    end else if (blank) begin
      pix_d = 8'h00;
    end
    und_d = und_set | (und_q & ~underrun_clr);
  end

  // State and datapath registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      rd_addr_q <= '0;
      buf_q     <= '0;
      pix_q     <= '0;
      und_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      rd_addr_q <= rd_addr_d;
      buf_q     <= buf_d;
      pix_q     <= pix_d;
      und_q     <= und_d;
    end
  end

endmodule

// File: tb/tb_pixel_fetch.sv
// Directed bench for pixel_fetch with a byte=addr[7:0] memory model.
// Counters are driven directly so the bench can jump across a frame.
module tb_pixel_fetch;

  logic        clk;
  logic        reset;
  logic [10:0] hcnt;
  logic [9:0]  vcnt;
  logic        rd_req;
  logic [15:0] rd_addr;
  logic        rd_ack;
  logic [7:0]  rd_data;
  logic [7:0]  pixels;
  logic        underrun;
  logic        underrun_clr;

  int n_chk;
  int n_fail;
  int age;
  bit hold;

  pixel_fetch dut (
    .clk          (clk),
    .reset        (reset),
    .hcounter     (hcnt),
    .vcounter     (vcnt),
    .rd_req       (rd_req),
    .rd_addr      (rd_addr),
    .rd_ack       (rd_ack),
    .rd_data      (rd_data),
    .pixels       (pixels),
    .underrun     (underrun),
    .underrun_clr (underrun_clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int dly(input logic [15:0] a);
    if (a == 16'd165) return 9;
    if (a == 16'd170) return 20;
    return 0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s h=%0d v=%0d observed=%0d expected=%0d",
             tag, hcnt, vcnt, obs, exp);
    end
  endtask

  // One pixel clock: advance counters and answer memory at negedge.
  task automatic cycle();
    @(negedge clk);
    if (hcnt == 11'd799) begin
      hcnt = 11'd0;
      vcnt = (vcnt == 10'd524) ? 10'd0 : vcnt + 10'd1;
    end else begin
      hcnt = hcnt + 11'd1;
    end
    if (rd_req && !hold) begin
      age = age + 1;
      if (age > dly(rd_addr)) begin
        rd_ack  = 1'b1;
        rd_data = rd_addr[7:0];
      end else begin
        rd_ack = 1'b0;
      end
    end else begin
      age    = 0;
      rd_ack = 1'b0;
    end
  endtask

  task automatic run_to(input int h, input int v);
    int n;
    n = 0;
    while (!(hcnt == 11'(h) && vcnt == 10'(v))) begin
      cycle();
      n++;
      if (n > 50000) begin
        n_chk++;
        n_fail++;
        $error("FAIL run_to timeout h=%0d v=%0d", h, v);
        break;
      end
    end
  endtask

  initial begin
    n_chk        = 0;
    n_fail       = 0;
    age          = 0;
    hold         = 1'b0;
    reset        = 1'b0;
    hcnt         = '0;
    vcnt         = '0;
    rd_ack       = 1'b0;
    rd_data      = '0;
    underrun_clr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_pixels", 32'(pixels), 0);
    chk("rst_rd_req", 32'(rd_req), 0);
    chk("rst_rd_addr", 32'(rd_addr), 0);
    chk("rst_underrun", 32'(underrun), 0);

    // Last visible line: groups 76..79 use words 0..3 after reset.
    reset = 1'b1;
    hcnt  = 11'd600;
    vcnt  = 10'd479;
    run_to(799, 479);
    hcnt = 11'd700;
    vcnt = 10'd524;
    run_to(760, 524);
    chk("pre_wrap_addr", 32'(rd_addr), 3);
    cycle();
    chk("wrap_req", 32'(rd_req), 1);
    chk("wrap_addr", 32'(rd_addr), 0);
    run_to(0, 0);
    chk("line0_grp0", 32'(pixels), 0);
    run_to(8, 0);
    chk("line0_grp1", 32'(pixels), 1);
    run_to(0, 1);
    chk("line1_grp0", 32'(pixels), 80);
    run_to(24, 1);
    for (int i = 0; i < 8; i++) begin
      chk("line1_grp3", 32'(pixels), 83);
      cycle();
    end
    chk("zero_wait_no_underrun", 32'(underrun), 0);

    // Late ack on word 165: group 5 of line 2 blanks.
    run_to(40, 2);
    for (int i = 0; i < 8; i++) begin
      chk("late_grp5", 32'(pixels), 0);
      cycle();
    end
    chk("late_underrun", 32'(underrun), 1);
    run_to(56, 2);
    for (int i = 0; i < 8; i++) begin
      chk("late_grp7", 32'(pixels), 167);
      cycle();
    end

    // Clear alone drops the flag.
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    chk("clr_alone", 32'(underrun), 0);

    // Clear together with a new underrun: set wins.
    run_to(79, 2);
    chk("pre_set_clear", 32'(underrun), 0);
    underrun_clr = 1'b1;
    cycle();
    underrun_clr = 1'b0;
    chk("set_beats_clr", 32'(underrun), 1);

    // Horizontal blanking and next-line prefetch address.
    run_to(640, 2);
    for (int i = 0; i < 160; i++) begin
      chk("hblank_pixels", 32'(pixels), 0);
      if (hcnt == 11'd761) chk("line3_addr", 32'(rd_addr), 240);
      cycle();
    end
    chk("line3_grp0", 32'(pixels), 240);

    // Vertical blanking: nothing shown, nothing requested.
    hcnt = 11'd700;
    vcnt = 10'd479;
    run_to(0, 480);
    for (int i = 0; i < 800; i++) begin
      chk("vblank_pixels", 32'(pixels), 0);
      chk("vblank_req", 32'(rd_req), 0);
      cycle();
    end

    // Async reset while a request is outstanding.
    hcnt = 11'd740;
    vcnt = 10'd524;
    run_to(9, 1);
    chk("pre_rst_grp1", 32'(pixels), 81);
    hold = 1'b1;
    run_to(17, 1);
    chk("pre_rst_req", 32'(rd_req), 1);
    chk("pre_rst_addr", 32'(rd_addr), 83);
    chk("pre_rst_grp2", 32'(pixels), 82);
    #2;
    reset = 1'b0;
    #1;
    chk("arst_rd_req", 32'(rd_req), 0);
    chk("arst_rd_addr", 32'(rd_addr), 0);
    chk("arst_pixels", 32'(pixels), 0);
    chk("arst_underrun", 32'(underrun), 0);
    cycle();
    reset = 1'b1;
    hold  = 1'b0;
    hcnt  = 11'd740;
    vcnt  = 10'd524;
    run_to(8, 0);
    chk("post_rst_line0", 32'(pixels), 1);
    run_to(24, 1);
    for (int i = 0; i < 8; i++) begin
      chk("post_rst_grp3", 32'(pixels), 83);
      cycle();
    end
    chk("post_rst_underrun", 32'(underrun), 0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/pixel_fetch.md
# pixel_fetch

Upstream feeder for the `vga` timing/colour stage. Reads a 1-bit-per-pixel 640x480 framebuffer from shared memory through a req/ack read port, one byte (8 pixels) at a time. Presents the byte for the current 8-pixel group on `pixels`, aligned to the `hcounter`/`vcounter` values the `vga` block produces. Prefetches one group ahead and flags late memory responses.

## Interface
- `H_VISIBLE`, 640: visible pixels per line; must be a multiple of 8.
- `H_TOTAL`, 800: clocks per line.
- `V_VISIBLE`, 480: visible lines.
- `V_TOTAL`, 525: lines per frame.
- `PREFETCH_H`, 760: hcounter at which group 0 of the next line is requested; must be > H_VISIBLE-1 and < H_TOTAL-1.
- `ADDR_W`, 16: byte-address width; 640*480/8 = 38400 words fit.

Ports:
- `clk`  in  1  pixel clock, 25.2 MHz.
- `reset`  in  1  asynchronous, active-low reset.
- `hcounter`  in  11  horizontal position from `vga`.
- `vcounter`  in  10  vertical position from `vga`.
- `rd_req`  out  1  read request to memory arbiter.
- `rd_addr`  out  ADDR_W  byte address; stable while `rd_req` is high.
- `rd_ack`  in  1  request accepted; `rd_data` is valid this cycle.
- `rd_data`  in  8  framebuffer byte; bit i is pixel x = 8*group + i.
- `pixels`  out  8  current group byte; `vga` uses bit hcounter[2:0].
- `underrun`  out  1  sticky; set when any group was not fetched in time.
- `underrun_clr`  in  1  synchronous clear of `underrun`.

## Operation
- **Address:** word = line*80 + group, tracked by an incrementing counter, with no multiplier. The counter resets to 0 at the fetch of line 0, group 0.
- **Fetch triggers:**
  - At hcounter == 8k, for k = 0..78, on a visible line: fetch group k+1 of the same line.
  - At hcounter == PREFETCH_H: fetch group 0 of the next line, but only if the next line is visible. Next line is vcounter+1, or 0 when vcounter == V_TOTAL-1.
  - No triggers occur for non-visible target lines.
- **FSM `IDLE` -> `REQ` -> `FULL`:**
  - `IDLE`, on trigger: drive `rd_req`=1 with the address, go to `REQ`.
  - `REQ`, on `rd_ack`=1: capture `rd_data` into the prefetch buffer, drop `rd_req` the next cycle, go to `FULL`.
  - `FULL`, on load event: go to `IDLE`.
  - Trigger while in `REQ` (previous fetch not yet acked): this trigger is skipped, `underrun` is set, and the address counter still advances so later groups stay aligned.
- **Load event:** on the clock edge where hcounter == 8k+7 (k = 0..78) on a visible line, or hcounter == H_TOTAL-1 with the next line visible.
  - If state is `FULL`: `pixels` <= buffer.
  - Otherwise: `pixels` <= 8'h00 and `underrun` is set.
- **Outside visible area:** at hcounter == H_VISIBLE-1, and at the final load of a line when the next line is not visible, `pixels` <= 8'h00.
- **Handshake rule:** once `rd_req` is high, it and `rd_addr` must not change until the cycle after `rd_ack`. Acks are accepted only in `REQ`; an ack in any other state is ignored.
- **Underrun flag:** `underrun_clr` and a set in the same cycle -> set wins.

## Timing
- **Reset values:** `pixels`=0, `rd_req`=0, `rd_addr`=0, `underrun`=0, FSM `IDLE`, address counter 0. Reset mid-request drops `rd_req` immediately; the arbiter must tolerate an abandoned request.
- **`pixels` update:** changes on the same edge that moves hcounter to 8k, so the `vga` combinational decode sees the new byte for all 8 clocks of group k.
- **Memory latency budget:** 7 cycles from trigger to `rd_ack` for in-line groups. For group 0: H_TOTAL-1-PREFETCH_H = 39 cycles.
- **Ack timing:** an ack on the load-event cycle itself counts as in time; the data is bypassed straight into `pixels`.
- **Wrap at end of frame:** the fetch for line 0 occurs at vcounter == 524, hcounter == PREFETCH_H.

## Structure
- A shared package `vga_pkg` holds the 640/800/480/525 timing constants and the 80-words-per-line constant. `vga` is to be migrated to it later.
- One natural sub-module: `fetch_sched`, the combinational trigger/load-event decode from hcounter/vcounter. The FSM, address counter and buffer stay in `pixel_fetch`.

## Test plan
- **Zero-wait memory:** ack 1 cycle after req, framebuffer byte = addr[7:0]. On line 1, group 3, `pixels` == 83 (word 83) for hcounter 24..31. No `underrun`.
- **Frame wrap:** at vcounter=524, hcounter=760, `rd_addr` == 0. At hcounter=0, line 0, `pixels` == mem[0].
- **Late ack:** ack delayed 9 cycles for group 5 of line 2 -> `pixels` == 8'h00 for hcounter 40..47, `underrun`=1. Group 7 still shows mem[167].
- **Blanking:** hcounter 640..799 and vcounter 480..524 -> `pixels` == 0, and no `rd_req` during vblank.
- **Async reset mid-request:** assert `reset`=0 while `rd_req`=1 -> `rd_req`=0 immediately and all outputs take reset values. After release, `pixels` is correct from the next frame's line 0.
- **Sticky flag:** `underrun_clr` asserted together with a new underrun -> `underrun` stays 1. Clear asserted alone -> `underrun`=0 the next cycle.
